// File: rtl/iob_im_frame_ctrl_if.sv
// CPU-side location write / commit bus of the frame sequencer.
// The swreg file drives the master side; the frame controller is the slave.
interface iob_im_frame_ctrl_if;
  logic        loc_wr_en;
  logic [1:0]  loc_wr_sel;
  logic [31:0] loc_wr_data;
  logic        commit_req;
  logic        commit_busy;
  logic [31:0] ball_loc;
  logic [31:0] barl_loc;
  logic [31:0] barr_loc;

  modport master (
    output loc_wr_en, loc_wr_sel, loc_wr_data, commit_req,
    input  commit_busy, ball_loc, barl_loc, barr_loc
  );

  modport slave (
    input  loc_wr_en, loc_wr_sel, loc_wr_data, commit_req,
    output commit_busy, ball_loc, barl_loc, barr_loc
  );
endinterface

// File: rtl/iob_im_frame_ctrl.sv
// Frame sequencer: VGA pixel timing plus double-buffered ball/bar locations.
// The active bank only changes at the start of vertical blanking.
module iob_im_frame_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_DIV  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  iob_im_frame_ctrl_if.slave   bus,
  output logic                 pix_en,
  output logic [9:0]           pixel_x,
  output logic [9:0]           pixel_y,
  output logic                 active_video,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 vblank,
  output logic [31:0]          frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_MAX  = 4'(PIX_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] Y_VB     = 10'(V_ACTIVE - 1);
  localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Location word layout; the upper tag bits are carried through untouched.
  typedef struct packed {
    logic [11:0] tag;
    logic [9:0]  y;
    logic [9:0]  x;
  } loc_t;

  typedef enum logic [1:0] {IDLE, ARMED, COMMIT} cst_t;

  logic [3:0] div_cnt, div_nxt;
  logic [9:0] x_nxt, y_nxt;
  logic       eol, eof, vb_ev;

  cst_t       st_q, st_nxt;
  logic       busy, do_commit;

  loc_t [2:0] pend_q;
  loc_t [2:0] act_q;

  // ---------------- pixel timing ----------------
  always_comb begin
    div_nxt = (div_cnt == DIV_MAX) ? 4'd0 : div_cnt + 4'd1;
    eol     = pix_en && (pixel_x == X_LAST);
    eof     = eol && (pixel_y == Y_LAST);
    vb_ev   = eol && (pixel_y == Y_VB);
    x_nxt   = pixel_x;
    y_nxt   = pixel_y;
    if (pix_en) begin
      x_nxt = eol ? 10'd0 : pixel_x + 10'd1;
      if (eol) y_nxt = (pixel_y == Y_LAST) ? 10'd0 : pixel_y + 10'd1;
    end
  end

  // Decodes use the next counter values so they switch with pixel_x/pixel_y.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt      <= '0;
      pix_en       <= 1'b0;
      pixel_x      <= '0;
      pixel_y      <= '0;
      active_video <= 1'b0;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      vblank       <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      div_cnt <= div_nxt;
      pix_en  <= (div_nxt == DIV_MAX);
      pixel_x <= x_nxt;
      pixel_y <= y_nxt;
      if (pix_en) begin
        active_video <= (x_nxt < X_ACT) && (y_nxt < Y_ACT);
        hsync        <= !((x_nxt >= HS_BEG) && (x_nxt < HS_END));
        vsync        <= !((y_nxt >= VS_BEG) && (y_nxt < VS_END));
        vblank       <= (y_nxt >= Y_ACT);
      end
      if (eof) frame_cnt <= frame_cnt + 32'd1;
    end
  end

  // ---------------- commit FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_nxt;
  end

  always_comb begin
    st_nxt = st_q;
    case (st_q)
      IDLE:    if (bus.commit_req) st_nxt = ARMED;
      ARMED:   if (vb_ev)          st_nxt = COMMIT;
      COMMIT:                      st_nxt = IDLE;
      default:                     st_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (st_q != IDLE);
    do_commit = (st_q == COMMIT);
  end

  // ---------------- location banks ----------------
  // A write in the COMMIT cycle only reaches pending; active takes the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      act_q  <= '0;
    end else begin
      if (do_commit) act_q <= pend_q;
      if (bus.loc_wr_en) begin
        case (bus.loc_wr_sel)
          2'd0:    pend_q[0] <= bus.loc_wr_data;
          2'd1:    pend_q[1] <= bus.loc_wr_data;
          2'd2:    pend_q[2] <= bus.loc_wr_data;
          default: ;
        endcase
      end
    end
  end

  assign bus.commit_busy = busy;
  assign bus.ball_loc    = act_q[0];
  assign bus.barl_loc    = act_q[1];
  assign bus.barr_loc    = act_q[2];

endmodule

// File: tb/tb_iob_im_frame_ctrl.sv
// Bench for iob_im_frame_ctrl on a shrunken raster; location updates are
// predicted into a scoreboard and matched when the active bank changes.
module tb_iob_im_frame_ctrl;
  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
  localparam int PD = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = PD * HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en, active_video, hsync, vsync, vblank;
  logic [9:0]  pixel_x, pixel_y;
  logic [31:0] frame_cnt;

  iob_im_frame_ctrl_if bus();

  iob_im_frame_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .PIX_DIV(PD)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .pix_en(pix_en), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .active_video(active_video), .hsync(hsync), .vsync(vsync),
    .vblank(vblank), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;

  // cyc counts clocks since reset release; the reset state is cycle 0.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Closed-form raster model indexed by cycle.
  function automatic int mx(int c); return (c / PD) % HT; endfunction
  function automatic int my(int c); return (c / (PD * HT)) % VT; endfunction
  function automatic bit is_vb(int c);
    return (c % PD == PD - 1) && mx(c) == HT - 1 && my(c) == VA - 1;
  endfunction
  function automatic int next_vb(int c);
    int v = c;
    while (!is_vb(v)) v++;
    return v;
  endfunction
  function automatic logic [4:0] mflags(int c);
    int x = mx(c);
    int y = my(c);
    logic pe = (c % PD) == PD - 1;
    logic av = (c >= PD) && x < HA && y < VA;
    logic h  = !(x >= HA + HFP && x < HA + HFP + HS);
    logic v  = !(y >= VA + VFP && y < VA + VFP + VS);
    logic vb = y >= VA;
    return {pe, av, h, v, vb};
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] ball, barl, barr;
    int          at;
  } exp_t;
  exp_t sbq[$];
  logic [31:0] pb, pl, pr;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pb <= bus.ball_loc; pl <= bus.barl_loc; pr <= bus.barr_loc;
    end else if (bus.ball_loc !== pb || bus.barl_loc !== pl || bus.barr_loc !== pr) begin
      if (sbq.size() == 0) begin
        chk("unexp_ball", bus.ball_loc, pb);
        chk("unexp_barl", bus.barl_loc, pl);
        chk("unexp_barr", bus.barr_loc, pr);
      end else begin
        e = sbq.pop_front();
        chk("upd_cyc",  cyc,          e.at);
        chk("upd_ball", bus.ball_loc, e.ball);
        chk("upd_barl", bus.barl_loc, e.barl);
        chk("upd_barr", bus.barr_loc, e.barr);
      end
      pb <= bus.ball_loc; pl <= bus.barl_loc; pr <= bus.barr_loc;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] d);
    bus.loc_wr_en = 1'b1; bus.loc_wr_sel = sel; bus.loc_wr_data = d;
    tick();
    bus.loc_wr_en = 1'b0;
  endtask

  task automatic commit(input logic [31:0] b, input logic [31:0] l, input logic [31:0] r,
                        input bit track, output int at);
    exp_t e;
    at = next_vb(cyc + 1) + 2;
    e.ball = b; e.barl = l; e.barr = r; e.at = at;
    if (track) sbq.push_back(e);
    bus.commit_req = 1'b1;
    tick();
    bus.commit_req = 1'b0;
    chk("busy_armed", bus.commit_busy, 1);
  endtask

  task automatic wait_row(input int y);
    int n = 0;
    while (!(my(cyc) == y && mx(cyc) == 0) && n < 2 * FRAME) begin tick(); n++; end
    chk("wait_row", my(cyc), y);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 2 * FRAME) begin tick(); n++; end
    chk("drain", sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int at;
    int avc, hlc, vlc;
    bus.loc_wr_en = 1'b0; bus.loc_wr_sel = 2'd0; bus.loc_wr_data = '0; bus.commit_req = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(20);

    // mid-line reset
    rst = 1'b1;
    tick(3);
    chk("rst_x",     pixel_x, 0);
    chk("rst_y",     pixel_y, 0);
    chk("rst_flags", {pix_en, active_video, hsync, vsync, vblank}, 5'b00110);
    chk("rst_fc",    frame_cnt, 0);
    chk("rst_busy",  bus.commit_busy, 0);
    chk("rst_locs",  {bus.ball_loc, bus.barl_loc, bus.barr_loc}, 0);
    rst = 1'b0;

    // raster timing over two frames, cycle by cycle
    avc = 0; hlc = 0; vlc = 0;
    for (int i = 0; i < 2 * FRAME + 5; i++) begin
      chk("tim_xy",    {pixel_x, pixel_y}, {10'(mx(cyc)), 10'(my(cyc))});
      chk("tim_flags", {pix_en, active_video, hsync, vsync, vblank}, mflags(cyc));
      chk("tim_fc",    frame_cnt, cyc / FRAME);
      if (cyc >= FRAME && cyc < 2 * FRAME) begin
        avc += int'(active_video);
        hlc += int'(!hsync);
        vlc += int'(!vsync);
      end
      tick();
    end
    chk("av_count",    avc, HA * VA * PD);
    chk("hsync_count", hlc, HS * PD * VT);
    chk("vsync_count", vlc, VS * HT * PD);

    // write without commit: active bank must not move
    wr(2'd0, 32'h0003_2064);
    wr(2'd3, 32'hDEAD_BEEF);
    tick(2 * FRAME);
    chk("nocommit_ball", bus.ball_loc, 0);

    // commit mid-frame, lands 2 clk after the VB pixel strobe
    wait_row(1);
    commit(32'h0003_2064, 32'h0, 32'h0, 1'b1, at);
    while (cyc < at - 1) tick();
    chk("busy_before", bus.commit_busy, 1);
    tick();
    chk("busy_after",  bus.commit_busy, 0);
    wait_drain();

    // write in the COMMIT cycle, plus a request while busy
    wr(2'd2, 32'h0000_0005);
    wait_row(1);
    commit(32'h0003_2064, 32'h0, 32'h5, 1'b1, at);
    bus.commit_req = 1'b1;
    tick();
    bus.commit_req = 1'b0;
    chk("busy_ignored", bus.commit_busy, 1);
    while (cyc < at - 1) tick();
    wr(2'd2, 32'h0001_9278);
    wait_drain();
    tick(FRAME);
    chk("no_extra_commit", bus.barr_loc, 32'h5);
    wait_row(1);
    commit(32'h0003_2064, 32'h0, 32'h0001_9278, 1'b1, at);
    wait_drain();

    // reset while armed drops the commit
    wait_row(1);
    wr(2'd0, 32'h0001_1111);
    commit(32'h0, 32'h0, 32'h0, 1'b0, at);
    tick(5);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("rstarm_busy", bus.commit_busy, 0);
    chk("rstarm_locs", {bus.ball_loc, bus.barl_loc, bus.barr_loc}, 0);
    tick(FRAME + 10);
    chk("rstarm_ball", bus.ball_loc, 0);
    chk("rstarm_idle", bus.commit_busy, 0);
    chk("sbq_empty",   sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
